pin_walk_checker: RTL
=====================

# pin_walk_checker

Loopback checker for the walking-one pin test. Sits directly downstream of the pin walker: the walker drives a one-hot pattern onto header pins, the board loops them back, and this block samples the returned pins, verifies that every step is a single-bit left rotation of the previous one, and reports lock, laps, error count and the sticky set of misbehaving pins. It is intended for LED/UART status on bring-up bitstreams.

## Interface
- NUM_PINS, 16, width of the walked pin bus
- CLOCK_FREQ_HZ, 100000000, system clock frequency
- DIVISOR, 4, walker step rate divisor; STEP_CYCLES = CLOCK_FREQ_HZ / DIVISOR
- TIMEOUT_CYCLES, 4*STEP_CYCLES, cycles without a step before a stuck error
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- pins_in  in  NUM_PINS  looped-back pins, asynchronous to clk
- locked  out  1  tracking a valid walk
- lap_pulse  out  1  one-cycle pulse on each accepted wrap to bit 0
- lap_count  out  16  accepted laps, wraps modulo 2^16
- err  out  1  sticky, set on any error
- err_count  out  8  error count, saturates at 255
- bad_pins  out  NUM_PINS  sticky OR of mismatching bit positions

## Operation
- Input path:
  - two-flop synchronizer s1 -> s2
  - s3 holds s2 delayed one cycle
  - sample is stable when s2 == s3; only stable samples are evaluated
- Registers:
  - prev: last accepted pattern
  - timer: cycles since last accepted step, width clog2(TIMEOUT_CYCLES+1)
- Expected pattern: exp = rotate-left-by-1(prev); bit NUM_PINS-1 wraps to bit 0.
- State SEARCH (locked=0):
  - a stable sample equal to 1 (bit 0 only) loads prev, clears timer, enters LOCKED
  - all other values (zero, multi-hot, any other one-hot) are ignored; no errors are counted
- State LOCKED (locked=1), evaluated in this priority order:
  - stable s2 != prev and s2 == exp: good step; prev <= s2, timer <= 0. If s2 == 1, lap_count increments and lap_pulse=1 for one cycle.
  - stable s2 != prev and s2 != exp: mismatch; bad_pins |= s2 ^ exp; enter SEARCH.
  - otherwise timer increments; on reaching TIMEOUT_CYCLES: stuck error, bad_pins |= exp, enter SEARCH.
- Every error sets err and increments err_count (saturating).
- Entering SEARCH clears timer. prev is reloaded only on relock.
- err, err_count and bad_pins are cleared only by reset. lap_count survives relock.
- Reset: state SEARCH; locked=0, lap_pulse=0, lap_count=0, err=0, err_count=0, bad_pins=0; prev, timer, s1, s2, s3 all 0.

## Timing
- A pin change first sampled into s1 at edge N is stable after edge N+2. prev, counters, state and outputs update at edge N+3.
- Minimum resolvable step: 2 cycles. A change lasting 1 cycle never becomes stable and is ignored.
- Lock: the relock step is accepted at edge N+3, and locked is high in that same cycle.
- The stuck error fires on the cycle timer reaches TIMEOUT_CYCLES, counted from the last accepted step. With default parameters this is 4 step periods.
- Reset asserted mid-lock takes effect at the next edge. The pipeline must refill, so evaluation resumes at the earliest 3 edges after reset release.
- All outputs are registered; no combinational path from pins_in.

## Test plan
- Loopback with the pin walker (NUM_PINS=16, CLOCK_FREQ_HZ=10, DIVISOR=4, STEP_CYCLES=2) for 3 laps -> locked=1 from the first bit-0 plus 3 edges; lap_count=3; three lap_pulses; err=0, err_count=0, bad_pins=0.
- Locked, then pins held at 0x0004 -> after 20 cycles without a step: err=1, err_count=1, locked=0, bad_pins=0x0008. Drive 0x0001 -> relock; lap_count unchanged.
- Skip: 0x0001, 0x0002, then 0x0008 -> bad_pins=0x000C, err_count=1, locked=0. Multi-hot 0x0006 after 0x0002 -> bad_pins gains 0x0002.
- One-cycle glitch 0x8000 while prev=0x0001 -> ignored. Next 0x0002 accepted with err=0.
- Force 300 mismatch/relock cycles -> err_count holds at 255 with no wrap.
- rst_n low for one cycle while locked with err=1 -> all outputs 0 next cycle, state SEARCH; relock works normally afterwards.

Source files
------------

// File: rtl/pin_walk_checker_if.sv
`default_nettype none
// ============================================================================
// pin_walk_checker_if : looped-back pin bus plus walk status reporting
// Revision 1.0
// ============================================================================
interface pin_walk_checker_if #(
  parameter int NUM_PINS = 16
);
  logic [NUM_PINS-1:0] pins_in;
  logic                locked;
  logic                lap_pulse;
  logic [15:0]         lap_count;
  logic                err;
  logic [7:0]          err_count;
  logic [NUM_PINS-1:0] bad_pins;

  modport master (
    output pins_in,
    input  locked, lap_pulse, lap_count, err, err_count, bad_pins
  );

  modport slave (
    input  pins_in,
    output locked, lap_pulse, lap_count, err, err_count, bad_pins
  );
endinterface
`default_nettype wire

// File: rtl/pin_walk_checker.sv
`default_nettype none
// ============================================================================
// pin_walk_checker : verifies a looped-back walking-one as single-bit rotations
// Revision 1.0
// ============================================================================
module pin_walk_checker #(
  parameter int NUM_PINS       = 16,
  parameter int CLOCK_FREQ_HZ  = 100000000,
  parameter int DIVISOR        = 4,
  parameter int STEP_CYCLES    = CLOCK_FREQ_HZ / DIVISOR,
  parameter int TIMEOUT_CYCLES = 4 * STEP_CYCLES
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  pin_walk_checker_if.slave bus
);

  localparam int                  c_TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0]     c_TIMEOUT = c_TW'(TIMEOUT_CYCLES);
  localparam logic [NUM_PINS-1:0] c_BIT0    = NUM_PINS'(1);

  typedef enum logic [0:0] {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [NUM_PINS-1:0] r_s1;
  logic [NUM_PINS-1:0] r_s2;
  logic [NUM_PINS-1:0] r_s3;
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] r_bad_pins;
  logic [c_TW-1:0]     r_timer;
  logic                r_locked;
  logic                r_lap_pulse;
  logic [15:0]         r_lap_count;
  logic                r_err;
  logic [7:0]          r_err_count;

  logic                w_stable;
  logic                w_changed;
  logic [NUM_PINS-1:0] w_exp;
  logic [c_TW-1:0]     w_timer_inc;
  logic                w_step;
  logic                w_mismatch;
  logic                w_stuck;
  logic                w_error;

  always_comb begin
    w_stable    = (r_s2 == r_s3);
    w_changed   = w_stable && (r_s2 != r_prev);
    w_exp       = {r_prev[NUM_PINS-2:0], r_prev[NUM_PINS-1]};
    w_timer_inc = r_timer + 1'b1;
    w_step      = (r_state == S_LOCKED) && w_changed && (r_s2 == w_exp);
    w_mismatch  = (r_state == S_LOCKED) && w_changed && (r_s2 != w_exp);
    // Stuck only when no stable change arrived this cycle
    w_stuck     = (r_state == S_LOCKED) && !w_changed && (w_timer_inc == c_TIMEOUT);
    w_error     = w_mismatch || w_stuck;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_SEARCH;
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= '0;
      r_prev      <= '0;
      r_timer     <= '0;
      r_locked    <= 1'b0;
      r_lap_pulse <= 1'b0;
      r_lap_count <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_bad_pins  <= '0;
    end else begin
      r_s1        <= bus.pins_in;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_lap_pulse <= 1'b0;

      if (w_error) begin
        r_err      <= 1'b1;
        r_bad_pins <= r_bad_pins | (w_mismatch ? (r_s2 ^ w_exp) : w_exp);
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end

      case (r_state)
        S_SEARCH: begin
          if (w_stable && (r_s2 == c_BIT0)) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
            r_prev   <= r_s2;
            r_timer  <= '0;
          end
        end
        S_LOCKED: begin
          if (w_step) begin
            r_prev  <= r_s2;
            r_timer <= '0;
            if (r_s2 == c_BIT0) begin
              r_lap_count <= r_lap_count + 16'd1;
              r_lap_pulse <= 1'b1;
            end
          end else if (w_error) begin
            r_state  <= S_SEARCH;
            r_locked <= 1'b0;
            r_timer  <= '0;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
          r_timer  <= '0;
        end
      endcase
    end
  end

  assign bus.locked    = r_locked;
  assign bus.lap_pulse = r_lap_pulse;
  assign bus.lap_count = r_lap_count;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.bad_pins  = r_bad_pins;

endmodule
`default_nettype wire
